// File: rtl/vector_memory_responder.sv
// Memory-side responder: byte-addressed RAM with a registered fetch port and a
// multi-cycle scalar/unit-stride vector load/store engine (one element per cycle).
module vector_memory_responder #(
  parameter int ADDR_WIDTH       = 17,
  parameter int LEN              = 32,
  parameter int BYTE_SIZE        = 8,
  parameter int VECTOR_SIZE      = 8,
  parameter int ENTRY_INDEX_SIZE = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy_in,
  input  logic                        inst_fetch_enabled,
  input  logic [ADDR_WIDTH-1:0]       mem_inst_addr,
  output logic [LEN-1:0]              instruction,
  input  logic                        mem_vis_enabled,
  input  logic [1:0]                  memory_vis_signal,
  input  logic [2:0]                  data_type,
  input  logic [ENTRY_INDEX_SIZE:0]   vector_length,
  input  logic [ADDR_WIDTH-1:0]       mem_data_addr,
  input  logic [LEN-1:0]              mem_write_scalar_data,
  input  logic [LEN*VECTOR_SIZE-1:0]  mem_write_vector_data,
  output logic [LEN-1:0]              mem_read_scalar_data,
  output logic [LEN*VECTOR_SIZE-1:0]  mem_read_vector_data,
  output logic [1:0]                  mem_vis_status
);
  localparam int VW = LEN*VECTOR_SIZE;
  localparam int CW = ENTRY_INDEX_SIZE+1;

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_ACCESS = 2'b01, S_DONE = 2'b10} state_t;

  logic [BYTE_SIZE-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

  state_t                      r_state, w_state_next;
  logic [ADDR_WIDTH-1:0]       r_addr;
  logic                        r_store;
  logic                        r_vec;
  logic [1:0]                  r_width;
  logic [VW-1:0]               r_wdata;
  logic [CW-1:0]               r_n;
  logic [ENTRY_INDEX_SIZE-1:0] r_cnt;
  logic [LEN-1:0]              r_inst;
  logic [LEN-1:0]              r_sdata;
  logic [VW-1:0]               r_vdata;

  logic                  w_accept, w_last;
  logic [CW-1:0]         w_n_in;
  logic [ADDR_WIDTH-1:0] w_eaddr, w_ea1, w_ea2, w_ea3;
  logic [ADDR_WIDTH-1:0] w_fa1, w_fa2, w_fa3;
  logic [LEN-1:0]        w_rd_word, w_ld_elem, w_wr_elem, w_fetch_word;

  assign instruction          = r_inst;
  assign mem_read_scalar_data = r_sdata;
  assign mem_read_vector_data = r_vdata;
  assign mem_vis_status       = r_state;

  assign w_accept = (r_state == S_IDLE) && mem_vis_enabled &&
                    ((memory_vis_signal == 2'b01) || (memory_vis_signal == 2'b10));
  assign w_n_in   = !data_type[2] ? CW'(1) :
                    (vector_length > CW'(VECTOR_SIZE)) ? CW'(VECTOR_SIZE) : vector_length;
  assign w_last   = ({1'b0, r_cnt} == (r_n - 1'b1));

  // Element address; the natural ADDR_WIDTH truncation gives the modulo wrap.
  always_comb begin
    case (r_width)
      2'b00:   w_eaddr = r_addr + ADDR_WIDTH'(r_cnt);
      2'b01:   w_eaddr = r_addr + (ADDR_WIDTH'(r_cnt) << 1);
      default: w_eaddr = r_addr + (ADDR_WIDTH'(r_cnt) << 2);
    endcase
  end
  assign w_ea1 = w_eaddr + ADDR_WIDTH'(1);
  assign w_ea2 = w_eaddr + ADDR_WIDTH'(2);
  assign w_ea3 = w_eaddr + ADDR_WIDTH'(3);
  assign w_rd_word = {r_mem[w_ea3], r_mem[w_ea2], r_mem[w_ea1], r_mem[w_eaddr]};

  assign w_fa1 = mem_inst_addr + ADDR_WIDTH'(1);
  assign w_fa2 = mem_inst_addr + ADDR_WIDTH'(2);
  assign w_fa3 = mem_inst_addr + ADDR_WIDTH'(3);
  assign w_fetch_word = {r_mem[w_fa3], r_mem[w_fa2], r_mem[w_fa1], r_mem[mem_inst_addr]};

  always_comb begin
    w_ld_elem = '0;
    w_wr_elem = '0;
    case (r_width)
      2'b00: begin
        w_ld_elem[BYTE_SIZE-1:0] = w_rd_word[BYTE_SIZE-1:0];
        w_wr_elem[BYTE_SIZE-1:0] = r_wdata[{r_cnt, 3'b000} +: BYTE_SIZE];
      end
      2'b01: begin
        w_ld_elem[2*BYTE_SIZE-1:0] = w_rd_word[2*BYTE_SIZE-1:0];
        w_wr_elem[2*BYTE_SIZE-1:0] = r_wdata[{r_cnt, 4'b0000} +: 2*BYTE_SIZE];
      end
      default: begin
        w_ld_elem = w_rd_word;
        w_wr_elem = r_wdata[{r_cnt, 5'b00000} +: LEN];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)         r_state <= S_IDLE;
    else if (rdy_in) r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_next = (w_n_in == '0) ? S_DONE : S_ACCESS;
      S_ACCESS: if (w_last) w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst  <= '0;
      r_sdata <= '0;
      r_vdata <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_store <= 1'b0;
      r_vec   <= 1'b0;
      r_width <= '0;
      r_wdata <= '0;
      r_n     <= '0;
    end else if (rdy_in) begin
      if (inst_fetch_enabled) r_inst <= w_fetch_word;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_addr  <= mem_data_addr;
          r_store <= (memory_vis_signal == 2'b10);
          r_vec   <= data_type[2];
          r_width <= data_type[1:0];
          r_wdata <= data_type[2] ? mem_write_vector_data : VW'(mem_write_scalar_data);
          r_n     <= w_n_in;
          r_cnt   <= '0;
          if (memory_vis_signal == 2'b01) begin
            if (data_type[2]) r_vdata <= '0;
            else              r_sdata <= '0;
          end
        end
        S_ACCESS: begin
          if (!r_store) begin
            if (!r_vec) r_sdata <= w_ld_elem;
            else begin
              case (r_width)
                2'b00:   r_vdata[{r_cnt, 3'b000} +: BYTE_SIZE]   <= w_rd_word[BYTE_SIZE-1:0];
                2'b01:   r_vdata[{r_cnt, 4'b0000} +: 2*BYTE_SIZE] <= w_rd_word[2*BYTE_SIZE-1:0];
                default: r_vdata[{r_cnt, 5'b00000} +: LEN]       <= w_rd_word;
              endcase
            end
          end
          if (!w_last) r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // RAM has no reset; a reset edge suppresses the store element in flight.
  always_ff @(posedge clk) begin
    if (!rst && rdy_in && (r_state == S_ACCESS) && r_store) begin
      r_mem[w_eaddr] <= w_wr_elem[BYTE_SIZE-1:0];
      if (r_width != 2'b00) r_mem[w_ea1] <= w_wr_elem[2*BYTE_SIZE-1:BYTE_SIZE];
      if (r_width[1]) begin
        r_mem[w_ea2] <= w_wr_elem[3*BYTE_SIZE-1:2*BYTE_SIZE];
        r_mem[w_ea3] <= w_wr_elem[4*BYTE_SIZE-1:3*BYTE_SIZE];
      end
    end
  end
endmodule

// File: tb/tb_vector_memory_responder.sv
// Directed bench for vector_memory_responder: scalar vector table plus
// hand-written multi-cycle sequences (wrap, interference, stall, reset abort).
module tb_vector_memory_responder;
  logic         clk = 1'b0;
  logic         rst, rdy_in, inst_fetch_enabled, mem_vis_enabled;
  logic [16:0]  mem_inst_addr, mem_data_addr;
  logic [31:0]  instruction, mem_write_scalar_data, mem_read_scalar_data;
  logic [1:0]   memory_vis_signal, mem_vis_status;
  logic [2:0]   data_type;
  logic [3:0]   vector_length;
  logic [255:0] mem_write_vector_data, mem_read_vector_data;

  int total = 0;
  int bad   = 0;

  localparam logic [255:0] P = 256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;
  localparam logic [255:0] P4 = 256'h44444444_33333333_22222222_11111111;
  localparam logic [255:0] H5 = 256'h0005_0004_0003_0002_0001;
  localparam logic [255:0] W4 = 256'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [255:0] F4 = 256'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0;

  always #5 clk = ~clk;

  vector_memory_responder dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in),
    .inst_fetch_enabled(inst_fetch_enabled), .mem_inst_addr(mem_inst_addr),
    .instruction(instruction), .mem_vis_enabled(mem_vis_enabled),
    .memory_vis_signal(memory_vis_signal), .data_type(data_type),
    .vector_length(vector_length), .mem_data_addr(mem_data_addr),
    .mem_write_scalar_data(mem_write_scalar_data),
    .mem_write_vector_data(mem_write_vector_data),
    .mem_read_scalar_data(mem_read_scalar_data),
    .mem_read_vector_data(mem_read_vector_data),
    .mem_vis_status(mem_vis_status)
  );

  typedef struct {
    logic        st;
    logic [2:0]  dt;
    logic [16:0] a;
    logic [31:0] sd;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive_req(input logic st, input logic [2:0] dt, input logic [3:0] vl,
                           input logic [16:0] a, input logic [31:0] sd, input logic [255:0] vd);
    mem_vis_enabled       = 1'b1;
    memory_vis_signal     = st ? 2'b10 : 2'b01;
    data_type             = dt;
    vector_length         = vl;
    mem_data_addr         = a;
    mem_write_scalar_data = sd;
    mem_write_vector_data = vd;
  endtask

  task automatic idle_req();
    mem_vis_enabled       = 1'b0;
    memory_vis_signal     = 2'b00;
    mem_write_scalar_data = 32'hFFFF_FFFF;
    mem_write_vector_data = '1;
  endtask

  // Issues one request, counts BUSY cycles, checks DONE lasts exactly one cycle.
  task automatic run_txn(input string nm, input logic st, input logic [2:0] dt,
                         input logic [3:0] vl, input logic [16:0] a, input logic [31:0] sd,
                         input logic [255:0] vd, input int exp_busy);
    int busy = 0;
    @(negedge clk);
    drive_req(st, dt, vl, a, sd, vd);
    @(negedge clk);
    idle_req();
    for (int k = 0; k < 40; k++) begin
      if (mem_vis_status != 2'b01) break;
      busy++;
      @(negedge clk);
    end
    chk({nm, "_done"}, 256'(mem_vis_status), 256'd2);
    chk({nm, "_busy"}, 256'(busy), 256'(exp_busy));
    @(negedge clk);
    chk({nm, "_idle"}, 256'(mem_vis_status), 256'd0);
  endtask

  task automatic ld_word(input string nm, input logic [16:0] a, input logic [31:0] exp);
    run_txn(nm, 1'b0, 3'b010, 4'd0, a, 32'd0, '0, 1);
    chk(nm, 256'(mem_read_scalar_data), 256'(exp));
  endtask

  initial begin
    int busy;
    rst = 1'b1; rdy_in = 1'b1; inst_fetch_enabled = 1'b0; mem_inst_addr = '0;
    data_type = '0; vector_length = '0; mem_data_addr = '0;
    idle_req();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_status", 256'(mem_vis_status), 256'd0);
    chk("rst_inst",   256'(instruction), 256'd0);
    chk("rst_sdata",  256'(mem_read_scalar_data), 256'd0);
    chk("rst_vdata",  mem_read_vector_data, 256'd0);

    tbl[0]  = '{1'b1, 3'b010, 17'h00100, 32'h00100513, 32'h0};
    tbl[1]  = '{1'b1, 3'b010, 17'h00200, 32'hDEADBEEF, 32'h0};
    tbl[2]  = '{1'b0, 3'b000, 17'h00201, 32'h0, 32'h000000BE};
    tbl[3]  = '{1'b0, 3'b001, 17'h00202, 32'h0, 32'h0000DEAD};
    tbl[4]  = '{1'b0, 3'b010, 17'h00200, 32'h0, 32'hDEADBEEF};
    tbl[5]  = '{1'b1, 3'b000, 17'h00203, 32'hFFFFFF77, 32'h0};
    tbl[6]  = '{1'b0, 3'b011, 17'h00200, 32'h0, 32'h77ADBEEF};
    tbl[7]  = '{1'b1, 3'b001, 17'h1FFFF, 32'hABCD1234, 32'h0};
    tbl[8]  = '{1'b0, 3'b001, 17'h1FFFF, 32'h0, 32'h00001234};
    tbl[9]  = '{1'b0, 3'b000, 17'h00000, 32'h0, 32'h00000012};
    tbl[10] = '{1'b0, 3'b000, 17'h1FFFF, 32'h0, 32'h00000034};
    tbl[11] = '{1'b0, 3'b001, 17'h00102, 32'h0, 32'h00000010};
    for (int i = 0; i < 12; i++) begin
      run_txn($sformatf("row%0d", i), tbl[i].st, tbl[i].dt, 4'd0, tbl[i].a, tbl[i].sd, '0, 1);
      if (!tbl[i].st) chk($sformatf("row%0d_data", i), 256'(mem_read_scalar_data), 256'(tbl[i].exp));
    end

    // Fetch: one-cycle latency, holds when disabled.
    @(negedge clk);
    inst_fetch_enabled = 1'b1; mem_inst_addr = 17'h100;
    @(negedge clk);
    chk("fetch_100", 256'(instruction), 256'h00100513);
    chk("fetch_status", 256'(mem_vis_status), 256'd0);
    inst_fetch_enabled = 1'b0; mem_inst_addr = 17'h200;
    @(negedge clk);
    chk("fetch_hold", 256'(instruction), 256'h00100513);
    inst_fetch_enabled = 1'b1;
    @(negedge clk);
    chk("fetch_200", 256'(instruction), 256'h77ADBEEF);
    inst_fetch_enabled = 1'b0;

    // Vector word store/load and halfword load with zeroed upper elements.
    run_txn("vst_w8", 1'b1, 3'b110, 4'd8, 17'h400, 32'd0, P, 8);
    run_txn("vld_w8", 1'b0, 3'b110, 4'd8, 17'h400, 32'd0, '0, 8);
    chk("vld_w8_data", mem_read_vector_data, P);
    run_txn("vst_h5", 1'b1, 3'b101, 4'd5, 17'h300, 32'd0, H5, 5);
    run_txn("vld_h5", 1'b0, 3'b101, 4'd5, 17'h300, 32'd0, '0, 5);
    chk("vld_h5_data", mem_read_vector_data, H5);

    // Length 0 leaves RAM alone; length 12 clamps to 8 elements.
    run_txn("pre500", 1'b1, 3'b010, 4'd0, 17'h500, 32'h11111111, '0, 1);
    run_txn("vst_l0", 1'b1, 3'b110, 4'd0, 17'h500, 32'd0, '1, 0);
    ld_word("l0_ram", 17'h500, 32'h11111111);
    run_txn("pre620", 1'b1, 3'b010, 4'd0, 17'h620, 32'h55555555, '0, 1);
    run_txn("vst_l12", 1'b1, 3'b110, 4'd12, 17'h600, 32'd0, P, 8);
    ld_word("l12_e7", 17'h61C, 32'h88888888);
    ld_word("l12_e8", 17'h620, 32'h55555555);

    // Address wrap at the top of RAM.
    run_txn("vst_wrap", 1'b1, 3'b110, 4'd4, 17'h1FFF8, 32'd0, W4, 4);
    ld_word("wrap_e1", 17'h1FFFC, 32'hBBBBBBBB);
    ld_word("wrap_e2", 17'h00000, 32'hCCCCCCCC);
    ld_word("wrap_e3", 17'h00004, 32'hDDDDDDDD);

    // Competing store request while BUSY must be ignored.
    @(negedge clk);
    drive_req(1'b0, 3'b110, 4'd4, 17'h400, 32'd0, '0);
    @(negedge clk);
    drive_req(1'b1, 3'b010, 4'd0, 17'h400, 32'd0, '0);
    busy = 0;
    for (int k = 0; k < 40; k++) begin
      if (mem_vis_status != 2'b01) break;
      busy++;
      if (busy == 2) idle_req();
      @(negedge clk);
    end
    idle_req();
    chk("intf_done", 256'(mem_vis_status), 256'd2);
    chk("intf_busy", 256'(busy), 256'd4);
    chk("intf_data", mem_read_vector_data, P4);
    ld_word("intf_ram", 17'h400, 32'h11111111);

    // rdy_in low for 3 edges mid-load stretches BUSY by exactly 3.
    @(negedge clk);
    drive_req(1'b0, 3'b110, 4'd4, 17'h400, 32'd0, '0);
    @(negedge clk);
    idle_req();
    busy = 0;
    for (int k = 0; k < 40; k++) begin
      if (mem_vis_status != 2'b01) break;
      busy++;
      if (busy == 2) rdy_in = 1'b0;
      if (busy == 5) rdy_in = 1'b1;
      @(negedge clk);
    end
    rdy_in = 1'b1;
    chk("stall_done", 256'(mem_vis_status), 256'd2);
    chk("stall_busy", 256'(busy), 256'd7);
    chk("stall_data", mem_read_vector_data, P4);

    // Reset after two stored elements aborts the rest.
    run_txn("pre708", 1'b1, 3'b010, 4'd0, 17'h708, 32'd0, '0, 1);
    run_txn("pre70c", 1'b1, 3'b010, 4'd0, 17'h70C, 32'd0, '0, 1);
    @(negedge clk);
    drive_req(1'b1, 3'b110, 4'd4, 17'h700, 32'd0, F4);
    @(negedge clk);
    idle_req();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_status", 256'(mem_vis_status), 256'd0);
    chk("abort_sdata", 256'(mem_read_scalar_data), 256'd0);
    ld_word("abort_e0", 17'h700, 32'hF0F0F0F0);
    ld_word("abort_e1", 17'h704, 32'hF1F1F1F1);
    ld_word("abort_e2", 17'h708, 32'h00000000);
    ld_word("abort_e3", 17'h70C, 32'h00000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vector_memory_responder.md
Name: vector_memory_responder

Overview:
- Memory-side responder for the vector core's memory interface.
- Holds a byte-addressed RAM of 2^ADDR_WIDTH bytes.
- Serves registered instruction fetches every cycle.
- Serves scalar and unit-stride vector loads/stores as multi-cycle transactions: one element per cycle, reported through mem_vis_status.

Parameters:
ADDR_WIDTH, 17, byte-address width; RAM size 2^ADDR_WIDTH bytes
LEN, 32, scalar word width in bits
BYTE_SIZE, 8, bits per byte
VECTOR_SIZE, 8, max elements per vector register at 32-bit SEW
ENTRY_INDEX_SIZE, 3, log2(VECTOR_SIZE)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
rdy_in  input  1  global enable; when 0, all state and outputs hold
inst_fetch_enabled  input  1  fetch request this cycle
mem_inst_addr  input  ADDR_WIDTH  fetch byte address
instruction  output  LEN  fetched word, registered
mem_vis_enabled  input  1  data request valid
memory_vis_signal  input  2  00 none, 01 load, 10 store, 11 treated as none
data_type  input  3  [2]=vector flag; [1:0] width: 00 byte, 01 half, 10/11 word
vector_length  input  ENTRY_INDEX_SIZE+1  element count for vector access
mem_data_addr  input  ADDR_WIDTH  base byte address
mem_write_scalar_data  input  LEN  scalar store data, low bits used
mem_write_vector_data  input  LEN*VECTOR_SIZE  vector store data; element i at bits [i*SEW +: SEW]
mem_read_scalar_data  output  LEN  scalar load result, zero-extended
mem_read_vector_data  output  LEN*VECTOR_SIZE  vector load result, packed like store data
mem_vis_status  output  2  00 IDLE, 01 BUSY, 10 DONE

Behaviour:
- Clock, reset and rdy_in:
  - Single clock domain: clk.
  - Reset is synchronous and active-high on rst.
  - Everything is gated by rdy_in=1.
- Reset values:
  - state=IDLE, mem_vis_status=00.
  - instruction=0, mem_read_scalar_data=0, mem_read_vector_data=0.
  - Element counter = 0.
  - RAM contents are not affected by reset.
- Fetch path:
  - Operates on every rising edge with inst_fetch_enabled=1.
  - instruction <= {mem[a+3],mem[a+2],mem[a+1],mem[a]}, little-endian, with a=mem_inst_addr.
  - Latency is 1 cycle. When not enabled, instruction holds.
  - The fetch path is independent of the data FSM. It is read-before-write against a same-edge store.
- FSM is IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - Accepts a request only when mem_vis_enabled=1 and memory_vis_signal is 01 or 10.
  - On acceptance, latches addr, op, width, vector flag and write data, and sets cnt=0.
  - Element count N: 1 for scalar; min(vector_length, VECTOR_SIZE) for vector.
  - If N=0 (vector with length 0): go directly to DONE with no RAM access and zero read data.
  - Otherwise clear the read-data register being loaded and go to ACCESS.
- ACCESS (status 01):
  - Each edge handles element cnt at address base + cnt*bytes(width), modulo 2^ADDR_WIDTH, little-endian.
  - Load: writes the element into the result at [cnt*SEW +: SEW]. Scalar loads write mem_read_scalar_data[SEW-1:0]; upper bits stay zero.
  - Store: writes bytes from the latched data.
  - When cnt=N-1, go to DONE; else cnt++.
- DONE (status 10):
  - Lasts exactly one cycle; read outputs are valid here and hold until the next accepted load.
  - Then go to IDLE.
- Requests while in ACCESS or DONE are ignored, not queued. The core drops mem_vis_enabled after observing DONE.
- Latency: accept edge, then N ACCESS edges. DONE is visible N+1 cycles after the accept edge.
- Load result beyond element N-1 reads as 0. Store never touches bytes beyond element N-1.
- Input changes after acceptance have no effect on the transaction in flight.
- rst asserted mid-transaction:
  - Abort to IDLE.
  - Stores already completed remain; remaining elements are not written.
- rdy_in=0 mid-transaction: freeze cnt, state and outputs; resume unchanged.

Test Plan:
- Reset, then fetch: preload mem[0x100..0x103]=13,05,10,00; fetch addr 0x100 -> instruction=0x00100513 one cycle later; mem_vis_status=00 throughout.
- Scalar word store then load: store 0xDEADBEEF @0x200, data_type=010 -> status 01 one cycle, then 10. Byte load @0x201 (data_type=000) -> mem_read_scalar_data=0x000000BE.
- Vector 16-bit load: data_type=101, vector_length=5, base 0x300 holding halfwords 1..5 -> BUSY 5 cycles, DONE at cycle 6; data[79:0] = {5,4,3,2,1} packed, data[255:80]=0.
- Vector store length 0, and vector_length=12: length 0 -> DONE next cycle, RAM unchanged. Length 12 at word width -> exactly 8 words written, 8 BUSY cycles.
- Boundary and interference:
  - Vector word store at base 2^17-8, length 4 -> elements 2,3 wrap to 0x0 and 0x4.
  - A second request during BUSY -> ignored.
  - rdy_in low 3 cycles mid-load -> completion delayed by exactly 3 cycles, same data.
- Reset mid vector store after 2 elements -> status 00 next cycle; only first 2 elements present in RAM.
